// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use hazards, EX-stage branch redirects and variable-latency
// data-memory waits. A memory access that never completes leads to a sticky
// ERROR state. The block also counts the cycles in which the PC was held.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_wb,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int                WC_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0]   WC_LAST = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [WC_W-1:0]   WC_ONE  = WC_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            memwait;
  logic            lu;

  // Hazard terms. A load targeting $zero never creates a dependency.
  always_comb begin
    memwait = dmem_req & ~dmem_ack;
    lu      = ex_mem_read && (ex_rd != 5'd0) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  end

  // Zero-latency stall/flush decode. Memory wait outranks a branch (the held
  // EX stage keeps the branch until the wait ends); a branch outranks a
  // load-use stall because the ID instruction is then wrong-path.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_wb  = 1'b0;
    if (!rst) begin
      if (state == ERROR || memwait) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        flush_wb  = 1'b1;
      end else if (branch_taken) begin
        flush_id  = 1'b1;
        flush_ex  = 1'b1;
      end else if (lu) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        flush_ex  = 1'b1;
      end
    end
  end

  // Sequencer FSM: tracks consecutive memory-wait cycles and latches the
  // fatal timeout. ERROR ignores every input; only reset leaves it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN, MEM_WAIT: begin
          if (memwait) begin
            if (wait_cnt == WC_LAST) begin
              state       <= ERROR;
              wait_cnt    <= '0;
              mem_timeout <= 1'b1;
            end else begin
              state       <= MEM_WAIT;
              wait_cnt    <= wait_cnt + WC_ONE;
            end
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        ERROR: begin
          state       <= ERROR;
          mem_timeout <= 1'b1;
        end
        default: begin
          state       <= RUN;
          wait_cnt    <= '0;
          mem_timeout <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall_if && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4, CNT_W=3.
// The driver applies one input vector per cycle and pushes the outputs the
// reference model predicts; the monitor compares them mid-cycle.
module tb_pipeline_hazard_ctrl;

  localparam int MT    = 4;
  localparam int CW    = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_rd;
  logic          id_uses_rt, ex_mem_read, branch_taken, dmem_req, dmem_ack;
  logic          stall_if, stall_id, stall_ex, stall_mem;
  logic          flush_id, flush_ex, flush_wb, mem_timeout;
  logic [CW-1:0] stall_cycles;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .stall_mem(stall_mem), .flush_id(flush_id), .flush_ex(flush_ex),
    .flush_wb(flush_wb), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Expected outputs: {stall_if,id,ex,mem, flush_id,ex,wb, mem_timeout, cnt}
  typedef struct {
    logic [10:0] v;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state, expressed as plain quantities.
  bit m_dead    = 0;   // a memory access has timed out
  int m_waited  = 0;   // consecutive stalled memory-wait cycles so far
  int m_stalls  = 0;   // PC-hold cycles since reset (saturating)

  function automatic logic [10:0] model_step(input bit r, input bit mr,
      input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
      input bit urt, input bit br, input bit req, input bit ack);
    bit sif, sid, sex, smem, fid, fex, fwb, mw, hz;
    logic [10:0] out;
    mw = req && !ack;
    hz = mr && rd != 0 && (rd == rs || (urt && rd == rt));
    {sif, sid, sex, smem, fid, fex, fwb} = '0;
    if (m_dead || mw)  {sif, sid, sex, smem, fwb} = 5'b11111;
    else if (br)       {fid, fex} = 2'b11;
    else if (hz)       {sif, sid, fex} = 3'b111;
    if (r) {sif, sid, sex, smem, fid, fex, fwb} = '0;
    out = {sif, sid, sex, smem, fid, fex, fwb, m_dead, CW'(m_stalls)};
    if (r) begin
      m_dead = 0; m_waited = 0; m_stalls = 0;
    end else begin
      if (sif && m_stalls < CMAX) m_stalls++;
      if (!m_dead) begin
        if (!mw)                 m_waited = 0;
        else if (m_waited == MT - 1) begin m_dead = 1; m_waited = 0; end
        else                     m_waited++;
      end
    end
    return out;
  endfunction

  // Apply one cycle of stimulus just after the edge and record the prediction.
  task automatic cyc(input int tag, input bit r, input bit mr,
      input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
      input bit urt, input bit br, input bit req, input bit ack);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_mem_read = mr; ex_rd = rd; id_rs = rs; id_rt = rt;
    id_uses_rt = urt; branch_taken = br; dmem_req = req; dmem_ack = ack;
    e.v   = model_step(r, mr, rd, rs, rt, urt, br, req, ack);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int tag);
    cyc(tag, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  // Monitor: compare the prediction for the current cycle mid-cycle.
  initial begin
    exp_t e;
    logic [10:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
               flush_wb, mem_timeout, stall_cycles};
        n_tests++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL outputs tag=%0d t=%0t got=%b expected=%b", e.tag,
                   $time, act, e.v);
        end
      end
    end
  end

  logic [4:0] regs [3];

  initial begin
    rst = 1; ex_mem_read = 0; ex_rd = 0; id_rs = 0; id_rt = 0;
    id_uses_rt = 0; branch_taken = 0; dmem_req = 0; dmem_ack = 0;
    regs[0] = 5'd0; regs[1] = 5'd5; regs[2] = 5'd7;
    repeat (2) @(posedge clk);

    // Reset state
    cyc(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    idle(0);

    // T1 load-use on rs for one cycle
    cyc(1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
    idle(1);
    // load-use through rt
    cyc(1, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 0);
    idle(1);

    // T2 $zero and unused rt
    cyc(2, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
    cyc(2, 0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0);

    // T3 memory wait acked on the third cycle, then same-cycle ack
    cyc(3, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    cyc(3, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    cyc(3, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
    cyc(3, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
    idle(3);

    // T5 branch beats load-use; memwait beats both
    cyc(5, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0);
    cyc(5, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 0);
    cyc(5, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0);

    // T4 timeout: 4 waited cycles, then ERROR ignoring a late ack
    cyc(4, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    repeat (5) cyc(4, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    cyc(4, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
    cyc(4, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0);
    cyc(4, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    idle(4);

    // T6 reset on the second wait cycle, then counter saturation
    cyc(6, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    cyc(6, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    idle(6);
    repeat (3) cyc(6, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    idle(6);
    repeat (10) cyc(6, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0);
    idle(6);

    // Randomized traffic with phases of slow memory and occasional resets
    for (int i = 0; i < 3000; i++) begin
      int ack_pct;
      ack_pct = ((i / 200) % 2 == 0) ? 50 : 8;
      cyc(7, ($urandom_range(99) < 3), $urandom_range(1),
          regs[$urandom_range(2)], regs[$urandom_range(2)],
          regs[$urandom_range(2)], $urandom_range(1),
          ($urandom_range(99) < 20), ($urandom_range(99) < 40),
          ($urandom_range(99) < ack_pct));
    end

    repeat (3) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
